timebase_ctrl: RTL and testbench

TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

---
 rtl/timebase_if.sv | 26 ++
 rtl/timebase_ctrl.sv | 101 ++++++++++
 tb/tb_timebase_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timebase_if.sv
// Control/status bundle between the timebase controller and its host.
// The master drives the buttons and pulses; the slave drives the outputs.
interface timebase_if #(
    parameter int ADDR_W = 9
);
    logic              btn_up;
    logic              btn_down;
    logic              arm;
    logic              trigger;
    logic [3:0]        range;
    logic              sample_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy;
    logic              done;

    modport master (
        output btn_up, btn_down, arm, trigger,
        input  range, sample_en, wr_en, wr_addr, busy, done
    );

    modport slave (
        input  btn_up, btn_down, arm, trigger,
        output range, sample_en, wr_en, wr_addr, busy, done
    );
endinterface

// File: rtl/timebase_ctrl.sv
// Timebase divider and capture sequencer for a sample buffer.
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | waiting for trigger
// CAPTURE | writing DEPTH samples, one per sample_en strobe
// DONE    | capture complete, waiting for re-arm
module timebase_ctrl #(
    parameter int RANGE_MAX = 15,
    parameter int DEPTH     = 512,
    parameter int ADDR_W    = 9
) (
    input logic       clk,
    input logic       rst,
    timebase_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t            state;
    logic [3:0]        range_r;
    logic [3:0]        range_nxt;
    logic [15:0]       div_cnt;
    logic [15:0]       div_last;
    logic              sample_en_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic              tick;
    logic              range_chg;
    logic              trig_go;
    logic              last_wr;

    assign div_last  = (16'd1 << range_r) - 16'd1;
    assign tick      = (div_cnt == div_last);
    assign range_chg = (range_nxt != range_r);
    assign trig_go   = (state == ARMED) && bus.trigger;
    assign last_wr   = wr_en_r && (wr_addr_r == ADDR_W'(DEPTH - 1));

    // Range is frozen during capture; opposing buttons cancel.
    always_comb begin
        range_nxt = range_r;
        if (state != CAPTURE && (bus.btn_up != bus.btn_down)) begin
            if (bus.btn_up && range_r != 4'(RANGE_MAX))
                range_nxt = range_r + 4'd1;
            else if (bus.btn_down && range_r != 4'd0)
                range_nxt = range_r - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            range_r     <= 4'd0;
            div_cnt     <= 16'd0;
            sample_en_r <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
        end else begin
            range_r <= range_nxt;
            // Restarting the divider keeps strobe spacing exact after a range
            // change and aligns the first write to the trigger.
            if (range_chg || trig_go) begin
                div_cnt     <= 16'd0;
                sample_en_r <= 1'b0;
            end else if (tick) begin
                div_cnt     <= 16'd0;
                sample_en_r <= 1'b1;
            end else begin
                div_cnt     <= div_cnt + 16'd1;
                sample_en_r <= 1'b0;
            end

            wr_en_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.arm) state <= ARMED;
                end
                ARMED: begin
                    if (bus.trigger) begin
                        state     <= CAPTURE;
                        wr_addr_r <= '0;
                    end
                end
                CAPTURE: begin
                    wr_en_r <= tick && !last_wr;
                    if (wr_en_r) wr_addr_r <= wr_addr_r + 1'b1;
                    if (last_wr) state <= DONE;
                end
                DONE: begin
                    if (bus.arm) state <= ARMED;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.range     = range_r;
    assign bus.sample_en = sample_en_r;
    assign bus.wr_en     = wr_en_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.busy      = (state == ARMED) || (state == CAPTURE);
    assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_timebase_ctrl.sv
// Self-checking bench for timebase_ctrl: per-scenario tasks plus a write
// scoreboard holding the expected address and cycle of every buffer write.
module tb_timebase_ctrl;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;

    typedef struct {
        int addr;
        int cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    exp_t sb[$];

    timebase_if #(.ADDR_W(ADDR_W)) tif ();

    timebase_ctrl #(.RANGE_MAX(15), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every observed write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (tif.wr_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_wr: wr_addr=%0d cycle=%0d, no write expected", tif.wr_addr, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (int'(tif.wr_addr) !== e.addr || cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL wr_seq: got addr=%0d cycle=%0d, expected addr=%0d cycle=%0d",
                             tif.wr_addr, cyc, e.addr, e.cyc);
                end
            end
        end
    end

    task automatic press(input bit up, input bit dn, input bit a, input bit t);
        @(negedge clk);
        tif.btn_up = up; tif.btn_down = dn; tif.arm = a; tif.trigger = t;
        @(posedge clk);
        #1;
        tif.btn_up = 0; tif.btn_down = 0; tif.arm = 0; tif.trigger = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
    endtask

    task automatic do_trigger(input int p);
        int c;
        press(0, 0, 0, 1);
        c = cyc;
        for (int k = 0; k < DEPTH; k++) sb.push_back('{addr: k, cyc: c + (k + 1) * p});
    endtask

    task automatic wait_done(input string name, input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (tif.done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, limit);
        end
        checks++;
        if (tif.busy !== 1'b0 || tif.wr_addr !== '0 || sb.size() != 0) begin
            failures++;
            $display("FAIL %s_end: busy=%b wr_addr=%0d pending=%0d, expected 0 0 0",
                     name, tif.busy, tif.wr_addr, sb.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({tif.range, tif.sample_en, tif.wr_en, tif.wr_addr, tif.busy, tif.done} !== '0) begin
            failures++;
            $display("FAIL reset_vals: range=%0d se=%b we=%b addr=%0d busy=%b done=%b, expected all 0",
                     tif.range, tif.sample_en, tif.wr_en, tif.wr_addr, tif.busy, tif.done);
        end
    endtask

    task automatic test_idle_ctrl();
        press(0, 0, 0, 1);
        @(negedge clk);
        checks++;
        if (tif.busy !== 1'b0 || tif.done !== 1'b0) begin
            failures++;
            $display("FAIL idle_trigger: busy=%b done=%b, expected 0 0", tif.busy, tif.done);
        end
        press(0, 0, 1, 1);
        repeat (20) @(negedge clk);
        checks++;
        if (tif.busy !== 1'b1 || tif.done !== 1'b0) begin
            failures++;
            $display("FAIL arm_trig_same: busy=%b done=%b, expected 1 0", tif.busy, tif.done);
        end
        apply_reset();
    endtask

    task automatic test_range_sat();
        repeat (16) press(1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (tif.range !== 4'd15) begin
            failures++;
            $display("FAIL range_max: range=%0d expected 15", tif.range);
        end
        repeat (20) press(0, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (tif.range !== 4'd0) begin
            failures++;
            $display("FAIL range_min: range=%0d expected 0", tif.range);
        end
        repeat (2) press(1, 0, 0, 0);
        press(1, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (tif.range !== 4'd2) begin
            failures++;
            $display("FAIL range_both: range=%0d expected 2", tif.range);
        end
    endtask

    // Range 2 -> 3: no strobe in the change cycle, next strobe 8 cycles later.
    task automatic test_range_change();
        int c;
        bit seen;
        press(1, 0, 0, 0);
        c = cyc;
        @(negedge clk);
        checks++;
        if (tif.sample_en !== 1'b0 || tif.range !== 4'd3) begin
            failures++;
            $display("FAIL range_chg_cycle: se=%b range=%0d, expected 0 3", tif.sample_en, tif.range);
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (tif.sample_en === 1'b1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen || cyc - c != 8) begin
            failures++;
            $display("FAIL range_chg_period: first strobe after %0d cycles (seen=%b), expected 8", cyc - c, seen);
        end
        @(negedge clk);
        c = cyc;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (tif.sample_en === 1'b1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen || cyc - c != 7) begin
            failures++;
            $display("FAIL free_run_period: strobe gap %0d (seen=%b), expected 8", cyc - c + 1, seen);
        end
    endtask

    task automatic test_capture_r0();
        apply_reset();
        press(0, 0, 1, 0);
        @(negedge clk);
        checks++;
        if (tif.busy !== 1'b1 || tif.done !== 1'b0) begin
            failures++;
            $display("FAIL armed_flags: busy=%b done=%b, expected 1 0", tif.busy, tif.done);
        end
        do_trigger(1);
        wait_done("cap_r0", 600);
    endtask

    task automatic test_done_ctrl();
        press(0, 0, 0, 1);
        repeat (20) @(negedge clk);
        checks++;
        if (tif.done !== 1'b1 || tif.busy !== 1'b0) begin
            failures++;
            $display("FAIL done_trigger: done=%b busy=%b, expected 1 0", tif.done, tif.busy);
        end
        press(0, 0, 1, 0);
        @(negedge clk);
        checks++;
        if (tif.done !== 1'b0 || tif.busy !== 1'b1) begin
            failures++;
            $display("FAIL done_rearm: done=%b busy=%b, expected 0 1", tif.done, tif.busy);
        end
    endtask

    task automatic test_capture_r3();
        apply_reset();
        repeat (3) press(1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (tif.range !== 4'd3) begin
            failures++;
            $display("FAIL r3_range: range=%0d expected 3", tif.range);
        end
        press(0, 0, 1, 0);
        do_trigger(8);
        wait_done("cap_r3", 4200);
    endtask

    task automatic test_capture_locked();
        apply_reset();
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        do_trigger(2);
        repeat (100) @(negedge clk);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (tif.range !== 4'd1 || tif.busy !== 1'b1) begin
            failures++;
            $display("FAIL cap_locked: range=%0d busy=%b, expected 1 1", tif.range, tif.busy);
        end
        wait_done("cap_locked", 1100);
        repeat (10) @(negedge clk);
        checks++;
        if (tif.done !== 1'b1 || tif.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done: done=%b busy=%b, expected 1 0", tif.done, tif.busy);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        apply_reset();
        repeat (2) press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        do_trigger(4);
        seen = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (tif.wr_addr === 9'd100) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL mid_reach: wr_addr=%0d, expected to reach 100", tif.wr_addr);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        checks++;
        if ({tif.range, tif.sample_en, tif.wr_en, tif.wr_addr, tif.busy, tif.done} !== '0) begin
            failures++;
            $display("FAIL mid_reset: range=%0d se=%b we=%b addr=%0d busy=%b done=%b, expected all 0",
                     tif.range, tif.sample_en, tif.wr_en, tif.wr_addr, tif.busy, tif.done);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (tif.busy !== 1'b0 || tif.done !== 1'b0) begin
            failures++;
            $display("FAIL mid_idle: busy=%b done=%b, expected 0 0", tif.busy, tif.done);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        rst = 1'b0;
        tif.btn_up = 0; tif.btn_down = 0; tif.arm = 0; tif.trigger = 0;
        test_reset();
        test_idle_ctrl();
        test_range_sat();
        test_range_change();
        test_capture_r0();
        test_done_ctrl();
        test_capture_r3();
        test_capture_locked();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
